rom_dl_loader: RTL and testbench
================================

# rom_dl_loader

Sits between the HPS ioctl download stream and the williams2 core's `dn_*` ROM-load port. It filters ioctl writes by index and re-registers them as the core's write stream. It tags each byte with a ROM region and checks that the download is sequential and complete. It also owns the core's reset: the core is held in reset during a download and for a fixed settle time afterwards, and runs only after a good ROM image.

## Interface
- `ROM_SIZE`, default 98304: exact byte count of a valid image.
- `SND_BASE`, default 17'h0C000: first byte address of the sound-ROM region.
- `GFX_BASE`, default 17'h0E000: first byte address of the graphics-ROM region.
- `SETTLE_CYCLES`, default 1024: number of `clock_12` cycles `core_reset` stays high after download end or a soft reset.

- `clock_12` in 1: system clock, 12 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: high while the HPS is streaming a file.
- `ioctl_index` in 8: file index. Only index 0 is accepted.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_addr` in 17: byte address.
- `ioctl_dout` in 8: byte data.
- `soft_reset` in 1: level; OSD reset or user button.
- `dn_addr` out 17: registered write address to the core.
- `dn_dout` out 8: registered write data to the core.
- `dn_wr` out 1: one-cycle write strobe to the core.
- `dn_region` out 2: region of the current `dn_addr`. 0 = program, 1 = sound, 2 = graphics, 3 is never produced.
- `core_reset` out 1: active-high reset to williams2.
- `rom_loaded` out 1: a complete image has been accepted.
- `byte_count` out 18: bytes accepted in the current or last download.
- `checksum` out 8: sum of accepted bytes, mod 256.
- `error` out 1: sticky; the last download was faulty.

## Operation
- Reset values:
  - state IDLE, `core_reset`=1, `rom_loaded`=0, `error`=0.
  - `dn_wr`=0, `dn_addr`=0, `dn_dout`=0, `dn_region`=0.
  - `byte_count`=0, `checksum`=0.
- A download is active when `ioctl_download`=1 and `ioctl_index`=0. A start is the first cycle the download becomes active.
- States:
  - IDLE: `core_reset`=1. Goes to LOAD on start.
  - LOAD: `core_reset`=1 and `rom_loaded`=0. On start, `byte_count`, `checksum` and `error` clear.
  - SETTLE: `core_reset`=1. A settle counter runs from 0 to SETTLE_CYCLES-1, then the block goes to RUN.
  - RUN: `core_reset`=0 and `rom_loaded`=1.
    - A start goes to LOAD.
    - `soft_reset`=1 goes to SETTLE with the counter cleared.
- Accepting a byte in LOAD: `ioctl_wr`=1 with index 0 and `ioctl_addr` < ROM_SIZE.
  - `dn_addr`/`dn_dout` latch the byte and `dn_wr` pulses.
  - `byte_count` increments.
  - `checksum` += data, 8-bit wrap.
- Sequence check: if an accepted byte has `ioctl_addr` ≠ `byte_count` (value before the increment), set `error`. The byte is still forwarded.
- Overflow: a write with `ioctl_addr` ≥ ROM_SIZE is not forwarded, does not count, and sets `error`.
- Writes with any non-zero index are ignored in every state.
- Download end, when `ioctl_download` falls while in LOAD:
  - If `byte_count` = ROM_SIZE and `error`=0: go to SETTLE.
  - Otherwise: go to IDLE with `error`=1. The core stays in reset until a new download.
- `dn_region` is decoded from the latched address:
  - < SND_BASE gives 0.
  - < GFX_BASE gives 1.
  - otherwise 2.
- `soft_reset` held high keeps the block in SETTLE with the counter at 0. The counter runs only after it is released.
- `soft_reset` is ignored in IDLE and LOAD.

## Timing
- Write latency: `ioctl_wr` in cycle N gives `dn_wr`=1 in cycle N+1, for exactly one cycle.
- Back-to-back `ioctl_wr` in every cycle must produce `dn_wr` in every cycle, with no byte dropped.
- A start in RUN raises `core_reset` in the cycle after the start edge.
- `ioctl_download` falling in cycle F gives:
  - state SETTLE in cycle F+1;
  - `core_reset` falling in cycle F+1+SETTLE_CYCLES;
  - `rom_loaded` rising in that same cycle.
- A write arriving in the same cycle that `ioctl_download` falls is still accepted and counted before the completeness check.
- Asserting `reset_n` low mid-download returns all outputs to their reset values at once.
  - The HPS stream resuming afterwards is not treated as a start until `ioctl_download` is seen low.
- `byte_count` is 18 bits, so ROM_SIZE up to 131072 is representable without wrap.

## Test plan
- Full image: ROM_SIZE=16, SETTLE_CYCLES=8, bytes 0x01..0x10 at addresses 0..15, then the download falls.
  - 16 `dn_wr` pulses, each one cycle after its `ioctl_wr`.
  - `checksum`=0x88, `byte_count`=16, `error`=0.
  - `core_reset` falls exactly 9 cycles after the fall, and `rom_loaded`=1.
- Short image: 15 bytes, then the download falls.
  - State IDLE, `error`=1, `core_reset` stays 1, `rom_loaded`=0.
- Out-of-order and overflow writes:
  - Address 5 written as the first byte gives `error`=1, and the byte is still forwarded.
  - Address 16 with ROM_SIZE=16 gives no `dn_wr` and `byte_count` unchanged.
- Index filter and regions:
  - Index 1 writes during a download give no `dn_wr`.
  - Addresses 0x0BFFF, 0x0C000 and 0x0E000 (default parameters) give `dn_region` 0, 1 and 2.
- Soft reset and re-download:
  - In RUN, `soft_reset` pulsed for 3 cycles: `core_reset`=1 for 3+SETTLE_CYCLES cycles.
  - A new index-0 download start in RUN: `core_reset`=1 on the next cycle, and `byte_count` and `checksum` clear to 0.
- `reset_n` pulsed low after 8 of 16 bytes: all outputs at their reset values.
  - The remaining writes, while the download stays high, produce no `dn_wr`.

Source files
------------

// File: rtl/rom_dl_loader.sv
// ROM download front-end for williams2: filters the HPS ioctl stream, forwards
// bytes to the core's dn_* port, validates the image and sequences core reset.
module rom_dl_loader #(
    parameter int unsigned ROM_SIZE      = 98304,
    parameter logic [16:0] SND_BASE      = 17'h0C000,
    parameter logic [16:0] GFX_BASE      = 17'h0E000,
    parameter int unsigned SETTLE_CYCLES = 1024
) (
    input  logic        clock_12,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [16:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        soft_reset,
    output logic [16:0] dn_addr,
    output logic [7:0]  dn_dout,
    output logic        dn_wr,
    output logic [1:0]  dn_region,
    output logic        core_reset,
    output logic        rom_loaded,
    output logic [17:0] byte_count,
    output logic [7:0]  checksum,
    output logic        error
);

    localparam int unsigned   CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [17:0]   ROM_SIZE_W  = 18'(ROM_SIZE);

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;

    state_t        state, state_next;
    logic [CW-1:0] settle_cnt;
    logic          active, active_q, start, loading, wr_idx0, in_range;
    logic          accept, overflow, seq_err, dl_end, good_end, settle_done;
    logic [17:0]   count_base, count_next;
    logic [7:0]    sum_base;
    logic          err_base, err_next;

    assign active   = ioctl_download && (ioctl_index == 8'd0);
    assign start    = active && !active_q;
    // The start cycle already counts as loading so a byte in that cycle is kept.
    assign loading  = (state == LOAD) || start;
    assign wr_idx0  = ioctl_wr && (ioctl_index == 8'd0);
    assign in_range = {1'b0, ioctl_addr} < ROM_SIZE_W;
    assign accept   = loading && wr_idx0 && in_range;
    assign overflow = loading && wr_idx0 && !in_range;

    assign count_base = start ? '0 : byte_count;
    assign sum_base   = start ? '0 : checksum;
    assign err_base   = start ? 1'b0 : error;
    assign seq_err    = accept && ({1'b0, ioctl_addr} != count_base);
    assign count_next = count_base + 18'(accept);
    assign err_next   = err_base || seq_err || overflow;

    assign dl_end      = (state == LOAD) && !start && !ioctl_download;
    assign good_end    = dl_end && (count_next == ROM_SIZE_W) && !err_next;
    assign settle_done = (settle_cnt == SETTLE_LAST) && !soft_reset;

    always_ff @(posedge clock_12 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = LOAD;
        end else begin
            unique case (state)
                IDLE:   state_next = IDLE;
                LOAD:   if (dl_end) state_next = good_end ? SETTLE : IDLE;
                SETTLE: if (settle_done) state_next = RUN;
                RUN:    if (soft_reset) state_next = SETTLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // soft_reset asserts core reset immediately, ahead of the RUN->SETTLE edge.
    always_comb begin
        core_reset = (state != RUN) || soft_reset;
    end

    // active_q resets high: a stream still running after reset is not a start.
    always_ff @(posedge clock_12 or negedge reset_n) begin
        if (!reset_n) begin
            active_q   <= 1'b1;
            settle_cnt <= '0;
            dn_wr      <= 1'b0;
            dn_addr    <= '0;
            dn_dout    <= '0;
            byte_count <= '0;
            checksum   <= '0;
            error      <= 1'b0;
            rom_loaded <= 1'b0;
        end else begin
            active_q <= active;
            if (state != SETTLE || soft_reset) settle_cnt <= '0;
            else                               settle_cnt <= settle_cnt + 1'b1;
            dn_wr <= accept;
            if (accept) begin
                dn_addr <= ioctl_addr;
                dn_dout <= ioctl_dout;
            end
            byte_count <= count_next;
            checksum   <= sum_base + (accept ? ioctl_dout : 8'd0);
            error      <= err_next || (dl_end && !good_end);
            if (state_next == LOAD)     rom_loaded <= 1'b0;
            else if (state_next == RUN) rom_loaded <= 1'b1;
        end
    end

    always_comb begin
        if (dn_addr < SND_BASE)      dn_region = 2'd0;
        else if (dn_addr < GFX_BASE) dn_region = 2'd1;
        else                         dn_region = 2'd2;
    end

endmodule

// File: tb/tb_rom_dl_loader.sv
// Directed bench for rom_dl_loader: table-driven download vectors plus
// hand-written settle, soft-reset, restart and mid-download reset sequences.
module tb_rom_dl_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download, ioctl_wr, soft_reset;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [16:0] ioctl_addr;
    logic [16:0] dn_addr;
    logic [7:0]  dn_dout, checksum;
    logic        dn_wr, core_reset, rom_loaded, error;
    logic [1:0]  dn_region;
    logic [17:0] byte_count;

    logic        d_download, d_wr;
    logic [16:0] d_addr, d_dn_addr;
    logic [7:0]  d_dout, d_dn_dout, d_checksum;
    logic        d_dn_wr, d_core_reset, d_rom_loaded, d_error;
    logic [1:0]  d_dn_region;
    logic [17:0] d_byte_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rom_dl_loader #(.ROM_SIZE(16), .SETTLE_CYCLES(8)) u_small (
        .clock_12(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .soft_reset(soft_reset), .dn_addr(dn_addr),
        .dn_dout(dn_dout), .dn_wr(dn_wr), .dn_region(dn_region),
        .core_reset(core_reset), .rom_loaded(rom_loaded), .byte_count(byte_count),
        .checksum(checksum), .error(error)
    );

    rom_dl_loader u_def (
        .clock_12(clk), .reset_n(reset_n), .ioctl_download(d_download),
        .ioctl_index(ioctl_index), .ioctl_wr(d_wr), .ioctl_addr(d_addr),
        .ioctl_dout(d_dout), .soft_reset(1'b0), .dn_addr(d_dn_addr),
        .dn_dout(d_dn_dout), .dn_wr(d_dn_wr), .dn_region(d_dn_region),
        .core_reset(d_core_reset), .rom_loaded(d_rom_loaded), .byte_count(d_byte_count),
        .checksum(d_checksum), .error(d_error)
    );

    typedef struct {
        logic        dl;
        logic [7:0]  idx;
        logic        wr;
        logic [16:0] addr;
        logic [7:0]  dout;
        logic        exp_wr;
        logic [17:0] exp_cnt;
        logic [7:0]  exp_sum;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic dl, input logic [7:0] idx, input logic wr,
                                input logic [16:0] addr, input logic [7:0] dout,
                                input logic ewr, input logic [17:0] ecnt,
                                input logic [7:0] esum, input logic eerr);
        vec_t v;
        v.dl = dl; v.idx = idx; v.wr = wr; v.addr = addr; v.dout = dout;
        v.exp_wr = ewr; v.exp_cnt = ecnt; v.exp_sum = esum; v.exp_err = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int i);
        ioctl_download = v.dl;
        ioctl_index    = v.idx;
        ioctl_wr       = v.wr;
        ioctl_addr     = v.addr;
        ioctl_dout     = v.dout;
        @(posedge clk); #1;
        chk($sformatf("v%0d dn_wr", i), dn_wr, v.exp_wr);
        if (v.exp_wr) begin
            chk($sformatf("v%0d dn_addr", i), dn_addr, v.addr);
            chk($sformatf("v%0d dn_dout", i), dn_dout, v.dout);
        end
        chk($sformatf("v%0d byte_count", i), byte_count, v.exp_cnt);
        chk($sformatf("v%0d checksum", i), checksum, v.exp_sum);
        chk($sformatf("v%0d error", i), error, v.exp_err);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " core_reset"}, core_reset, 1);
        chk({nm, " rom_loaded"}, rom_loaded, 0);
        chk({nm, " error"}, error, 0);
        chk({nm, " dn_wr"}, dn_wr, 0);
        chk({nm, " dn_addr"}, dn_addr, 0);
        chk({nm, " dn_dout"}, dn_dout, 0);
        chk({nm, " dn_region"}, dn_region, 0);
        chk({nm, " byte_count"}, byte_count, 0);
        chk({nm, " checksum"}, checksum, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1_lo, s1_hi, s2_lo, s2_hi, s3_lo, s3_hi, s4a_lo, s4a_hi, s4b_lo, s4b_hi;
        int k, hi, bad;
        logic [7:0]  run_sum;
        logic [16:0] ra [3];

        // Full image: bytes 1..16 at addresses 0..15, then fall.
        s1_lo = tbl.size();
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        run_sum = 0;
        for (int i = 0; i < 16; i++) begin
            run_sum = run_sum + 8'(i + 1);
            tbl.push_back(mk(1, 0, 1, 17'(i), 8'(i + 1), 1, 18'(i + 1), run_sum, 0));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16, 8'h88, 0));
        s1_hi = tbl.size();

        // Short image after a restart from RUN: 15 bytes, then fall.
        s2_lo = tbl.size();
        run_sum = 0;
        for (int i = 0; i < 15; i++) begin
            run_sum = run_sum + 8'(i + 1);
            tbl.push_back(mk(1, 0, 1, 17'(i), 8'(i + 1), 1, 18'(i + 1), run_sum, 0));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 15, 8'h78, 1));
        s2_hi = tbl.size();

        // Out-of-order first byte, overflow address, index-1 write, then fall.
        s3_lo = tbl.size();
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 5, 8'hA5, 1, 1, 8'hA5, 1));
        tbl.push_back(mk(1, 0, 1, 16, 8'h33, 0, 1, 8'hA5, 1));
        tbl.push_back(mk(1, 1, 1, 1, 8'h77, 0, 1, 8'hA5, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8'hA5, 1));
        s3_hi = tbl.size();

        // Eight good bytes before a reset_n pulse.
        s4a_lo = tbl.size();
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        run_sum = 0;
        for (int i = 0; i < 8; i++) begin
            run_sum = run_sum + 8'(8'h10 + i);
            tbl.push_back(mk(1, 0, 1, 17'(i), 8'(8'h10 + i), 1, 18'(i + 1), run_sum, 0));
        end
        s4a_hi = tbl.size();

        // Stream continues after reset with download still high: nothing forwarded.
        s4b_lo = tbl.size();
        for (int i = 8; i < 16; i++)
            tbl.push_back(mk(1, 0, 1, 17'(i), 8'(8'h10 + i), 0, 0, 0, 0));
        s4b_hi = tbl.size();

        reset_n = 0; ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0;
        ioctl_addr = 0; ioctl_dout = 0; soft_reset = 0;
        d_download = 0; d_wr = 0; d_addr = 0; d_dout = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("por");
        chk("por def core_reset", d_core_reset, 1);
        reset_n = 1;
        @(posedge clk); #1;

        // Region decode with default parameters.
        ra[0] = 17'h0BFFF; ra[1] = 17'h0C000; ra[2] = 17'h0E000;
        d_download = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            d_wr = 1; d_addr = ra[i]; d_dout = 8'(i);
            @(posedge clk); #1;
            chk($sformatf("region%0d dn_wr", i), d_dn_wr, 1);
            chk($sformatf("region%0d dn_region", i), d_dn_region, i);
        end
        d_wr = 0; d_download = 0;
        @(posedge clk); #1;
        chk("region idle dn_wr", d_dn_wr, 0);

        for (int i = s1_lo; i < s1_hi; i++) run_vec(tbl[i], i);
        chk("full checksum", checksum, 8'h88);
        chk("settle core_reset", core_reset, 1);
        chk("settle rom_loaded", rom_loaded, 0);
        k = 1;
        while (core_reset && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("settle cycles", k, 9);
        chk("run core_reset", core_reset, 0);
        chk("run rom_loaded", rom_loaded, 1);

        // Three-cycle soft reset pulse in RUN.
        soft_reset = 1;
        hi = 0;
        for (int c = 0; c < 60; c++) begin
            if (c == 3) soft_reset = 0;
            #1;
            if (!core_reset) break;
            hi++;
            @(posedge clk); #1;
        end
        chk("soft reset cycles", hi, 11);
        chk("soft rom_loaded", rom_loaded, 1);

        // Restart from RUN.
        ioctl_download = 1; ioctl_index = 0; ioctl_wr = 0;
        #1;
        chk("restart same-cycle core_reset", core_reset, 0);
        @(posedge clk); #1;
        chk("restart core_reset", core_reset, 1);
        chk("restart byte_count", byte_count, 0);
        chk("restart checksum", checksum, 0);
        chk("restart rom_loaded", rom_loaded, 0);

        for (int i = s2_lo; i < s2_hi; i++) run_vec(tbl[i], i);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (core_reset !== 1'b1 || rom_loaded !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        chk("short image held in reset", bad, 0);

        for (int i = s3_lo; i < s3_hi; i++) run_vec(tbl[i], i);

        for (int i = s4a_lo; i < s4a_hi; i++) run_vec(tbl[i], i);
        reset_n = 0;
        ioctl_addr = 8; ioctl_dout = 8'h18;
        #1;
        chk_reset_vals("midreset");
        @(posedge clk); #1;
        reset_n = 1;
        for (int i = s4b_lo; i < s4b_hi; i++) run_vec(tbl[i], i);
        chk("post-reset core_reset", core_reset, 1);

        ioctl_download = 0; ioctl_wr = 0;
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
